// File: rtl/lfsr_pkg.sv
// Shared LFSR types and the reference next-state function for both topologies.
package lfsr_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } fsm_t;

   // Operates on a zero-extended 64-bit state. Callers truncate the result to their own width.
   function automatic logic [63:0] lfsr_next(
      input logic [63:0] state,
      input logic [63:0] taps,
      input int          width,
      input logic        mode
   );
      logic [63:0] nxt;
      logic        fb;
      nxt = state >> 1;
      if (mode) begin
         nxt = nxt ^ ({64{state[0]}} & taps);
      end else begin
         fb = ^(state & taps);
         nxt[width-1] = fb;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational LFSR successor for Fibonacci (MODE=0) or Galois (MODE=1) topology.
module lfsr_step
   import lfsr_pkg::*;
#(
   parameter int               WIDTH = 20,
   parameter logic [WIDTH-1:0] TAPS  = 20'h08881,
   parameter int               MODE  = 0
) (
   input  logic [WIDTH-1:0] cur,
   output logic [WIDTH-1:0] nxt
);

   assign nxt = WIDTH'(lfsr_next(64'(cur), 64'(TAPS), WIDTH, (MODE != 0)));

endmodule

// File: rtl/lfsr_engine.sv
// Parametrised LFSR with seed load, N-step bursts and zero-lockup recovery; all outputs registered.
// One step per cycle; a burst of N steps ends with done after N cycles. No backpressure: load aborts a burst.
// Optional period monitor (wrap/period ports) is enabled by defining LFSR_PERIOD_MON_EN.
module lfsr_engine
   import lfsr_pkg::*;
#(
   parameter int               WIDTH = 20,
   parameter logic [WIDTH-1:0] TAPS  = 20'h08881,
   parameter logic [WIDTH-1:0] SEED  = 20'h99999,
   parameter int               MODE  = 0,
   parameter int               CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             step_en,
   input  logic             burst_start,
   input  logic [CNT_W-1:0] burst_len,
   output logic [WIDTH-1:0] lfsr,
   output logic             busy,
   output logic             done,
   output logic             lockup
`ifdef LFSR_PERIOD_MON_EN
   ,
   output logic             wrap,
   output logic [63:0]      period
`endif
);

   fsm_t             st;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] nxt;

   lfsr_step #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS),
      .MODE  (MODE)
   ) u_step (
      .cur (lfsr),
      .nxt (nxt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr   <= SEED;
         st     <= IDLE;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         lockup <= 1'b0;
      end else begin
         done   <= 1'b0;
         lockup <= 1'b0;
         // Zero state is a fixed point; recovery preempts everything and leaves a burst running.
         if (lfsr == '0) begin
            lfsr   <= SEED;
            lockup <= 1'b1;
         end else if (load) begin
            lfsr <= load_val;
            st   <= IDLE;
            cnt  <= '0;
            busy <= 1'b0;
         end else if (st == IDLE) begin
            if (burst_start) begin
               if (burst_len != '0) begin
                  st   <= RUN;
                  cnt  <= burst_len;
                  busy <= 1'b1;
               end else begin
                  done <= 1'b1;
               end
            end else if (step_en) begin
               lfsr <= nxt;
            end
         end else begin
            lfsr <= nxt;
            if (cnt == CNT_W'(1)) begin
               st   <= IDLE;
               cnt  <= '0;
               busy <= 1'b0;
               done <= 1'b1;
            end else begin
               cnt <= cnt - 1'b1;
            end
         end
      end
   end

`ifdef LFSR_PERIOD_MON_EN
   logic [WIDTH-1:0] ref_val;
   logic [63:0]      since;
   logic             step_take;

   assign step_take = (lfsr != '0) && !load &&
                      (((st == IDLE) && !burst_start && step_en) || (st == RUN));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ref_val <= SEED;
         since   <= '0;
         wrap    <= 1'b0;
         period  <= '0;
      end else begin
         wrap <= 1'b0;
         if (lfsr == '0) begin
            ref_val <= SEED;
            since   <= '0;
         end else if (load) begin
            ref_val <= load_val;
            since   <= '0;
         end else if (step_take) begin
            if (nxt == ref_val) begin
               wrap   <= 1'b1;
               period <= since + 64'd1;
               since  <= '0;
            end else begin
               since <= since + 64'd1;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_lfsr_engine.sv
// Self-checking bench: three lfsr_engine builds (Fibonacci-20, Galois-20, Fibonacci-4) against a behavioural model.
module tb_lfsr_engine;

   logic        clk = 1'b0;
   logic        rst;
   logic        load, step_en, burst_start;
   logic [15:0] burst_len;
   logic [19:0] lv20;
   logic [3:0]  lv4;
   logic [19:0] lf_f, lf_g;
   logic [3:0]  lf_s;
   logic [2:0]  busy_o, done_o, lock_o;
`ifdef LFSR_PERIOD_MON_EN
   logic [2:0]  wrap_o;
   logic [63:0] period_o [3];
`endif

   int checks = 0;
   int errors = 0;

   logic [63:0] p_taps [3] = '{64'h08881, 64'h08881, 64'h3};
   logic [63:0] p_seed [3] = '{64'h99999, 64'h99999, 64'h1};
   int          p_w    [3] = '{20, 20, 4};
   bit          p_mode [3] = '{1'b0, 1'b1, 1'b0};

   logic [63:0] m_lf [3], m_ref [3], m_since [3], m_period [3];
   bit          m_run [3], m_busy [3], m_done [3], m_lock [3], m_wrap [3];
   int          m_rem [3];

   lfsr_engine dut_f (
      .clk(clk), .rst(rst), .load(load), .load_val(lv20), .step_en(step_en),
      .burst_start(burst_start), .burst_len(burst_len), .lfsr(lf_f),
      .busy(busy_o[0]), .done(done_o[0]), .lockup(lock_o[0])
`ifdef LFSR_PERIOD_MON_EN
      , .wrap(wrap_o[0]), .period(period_o[0])
`endif
   );

   lfsr_engine #(.MODE(1)) dut_g (
      .clk(clk), .rst(rst), .load(load), .load_val(lv20), .step_en(step_en),
      .burst_start(burst_start), .burst_len(burst_len), .lfsr(lf_g),
      .busy(busy_o[1]), .done(done_o[1]), .lockup(lock_o[1])
`ifdef LFSR_PERIOD_MON_EN
      , .wrap(wrap_o[1]), .period(period_o[1])
`endif
   );

   lfsr_engine #(.WIDTH(4), .TAPS(4'h3), .SEED(4'h1)) dut_s (
      .clk(clk), .rst(rst), .load(load), .load_val(lv4), .step_en(step_en),
      .burst_start(burst_start), .burst_len(burst_len), .lfsr(lf_s),
      .busy(busy_o[2]), .done(done_o[2]), .lockup(lock_o[2])
`ifdef LFSR_PERIOD_MON_EN
      , .wrap(wrap_o[2]), .period(period_o[2])
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] mstep(input logic [63:0] s, input int i);
      logic [63:0] r;
      r = s >> 1;
      if (p_mode[i]) begin
         if (s[0]) r = r ^ p_taps[i];
      end else if (($countones(s & p_taps[i]) % 2) == 1) begin
         r = r | (64'd1 << (p_w[i] - 1));
      end
      return r;
   endfunction

   function automatic logic [63:0] get_lf(input int i);
      case (i)
         0:       return 64'(lf_f);
         1:       return 64'(lf_g);
         default: return 64'(lf_s);
      endcase
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_lf[i] = p_seed[i]; m_ref[i] = p_seed[i];
         m_since[i] = 0; m_period[i] = 0;
         m_run[i] = 0; m_busy[i] = 0; m_done[i] = 0; m_lock[i] = 0; m_wrap[i] = 0;
         m_rem[i] = 0;
      end
   endtask

   task automatic model_clock();
      for (int i = 0; i < 3; i++) begin
         logic [63:0] lv;
         bit          stepped;
         lv = (i == 2) ? 64'(lv4) : 64'(lv20);
         stepped = 0;
         m_done[i] = 0; m_lock[i] = 0; m_wrap[i] = 0;
         if (m_lf[i] == 0) begin
            m_lf[i] = p_seed[i]; m_lock[i] = 1;
            m_ref[i] = p_seed[i]; m_since[i] = 0;
         end else if (load) begin
            m_lf[i] = lv; m_run[i] = 0; m_rem[i] = 0;
            m_ref[i] = lv; m_since[i] = 0;
         end else if (!m_run[i]) begin
            if (burst_start) begin
               if (burst_len != 0) begin
                  m_run[i] = 1; m_rem[i] = int'(burst_len);
               end else begin
                  m_done[i] = 1;
               end
            end else if (step_en) begin
               m_lf[i] = mstep(m_lf[i], i); stepped = 1;
            end
         end else begin
            m_lf[i] = mstep(m_lf[i], i); stepped = 1;
            m_rem[i]--;
            if (m_rem[i] == 0) begin
               m_run[i] = 0; m_done[i] = 1;
            end
         end
         if (stepped) begin
            if (m_lf[i] == m_ref[i]) begin
               m_wrap[i] = 1; m_period[i] = m_since[i] + 1; m_since[i] = 0;
            end else begin
               m_since[i]++;
            end
         end
         m_busy[i] = m_run[i];
      end
   endtask

   task automatic compare_all();
      for (int i = 0; i < 3; i++) begin
         check($sformatf("lfsr%0d", i), get_lf(i), m_lf[i]);
         check($sformatf("busy%0d", i), 64'(busy_o[i]), 64'(m_busy[i]));
         check($sformatf("done%0d", i), 64'(done_o[i]), 64'(m_done[i]));
         check($sformatf("lockup%0d", i), 64'(lock_o[i]), 64'(m_lock[i]));
`ifdef LFSR_PERIOD_MON_EN
         check($sformatf("wrap%0d", i), 64'(wrap_o[i]), 64'(m_wrap[i]));
         check($sformatf("period%0d", i), period_o[i], m_period[i]);
`endif
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_clock();
      #1;
      compare_all();
   endtask

   initial begin
      logic [63:0] exp5;
      int          nb;
      bit          seen_done;

      rst = 1'b1; load = 0; step_en = 0; burst_start = 0; burst_len = 0;
      lv20 = 0; lv4 = 0;
      model_reset();
      #12;
      compare_all();
      check("t1_reset_seed", 64'(lf_f), 64'h99999);
      check("t1_reset_busy", 64'(busy_o), 64'h0);
      @(negedge clk);
      rst = 1'b0;

      // T1: one Fibonacci step from the default seed
      step_en = 1; tick(); step_en = 0;
      check("t1_fib_step", 64'(lf_f), 64'h4CCCC);

      // T2: Galois step from 1 gives the tap mask
      load = 1; lv20 = 20'h00001; lv4 = 4'h1; tick(); load = 0;
      check("t2_load", 64'(lf_g), 64'h1);
      step_en = 1; tick(); step_en = 0;
      check("t2_galois", 64'(lf_g), 64'h08881);

      // T3: five-step burst
      exp5 = m_lf[0];
      repeat (5) exp5 = mstep(exp5, 0);
      burst_start = 1; burst_len = 16'd5; tick(); burst_start = 0; step_en = 1;
      nb = 0; seen_done = 0;
      for (int k = 0; k < 20 && !seen_done; k++) begin
         if (busy_o[0]) nb++;
         tick();
         if (done_o[0]) begin
            seen_done = 1;
            check("t3_busy_low_at_done", 64'(busy_o[0]), 64'h0);
         end
      end
      step_en = 0;
      check("t3_done_seen", 64'(seen_done), 64'h1);
      check("t3_busy_cycles", 64'(nb), 64'd5);
      check("t3_lfsr_5_steps", 64'(lf_f), exp5);

      // T4: load aborts a running burst with no done
      burst_start = 1; burst_len = 16'd10; tick(); burst_start = 0;
      tick(); tick();
      load = 1; lv20 = 20'h12345; lv4 = 4'h6; tick(); load = 0;
      check("t4_load_val", 64'(lf_f), 64'h12345);
      check("t4_busy", 64'(busy_o[0]), 64'h0);
      for (int k = 0; k < 12; k++) begin
         tick();
         check("t4_no_done", 64'(done_o[0]), 64'h0);
      end

      // T5: loaded zero recovers to SEED with a lockup pulse
      load = 1; lv20 = 0; lv4 = 0; tick(); load = 0;
      check("t5_zero", 64'(lf_f), 64'h0);
      tick();
      check("t5_seed", 64'(lf_f), 64'h99999);
      check("t5_seed_small", 64'(lf_s), 64'h1);
      check("t5_lockup", 64'(lock_o[0]), 64'h1);
      tick();
      check("t5_lockup_drop", 64'(lock_o[0]), 64'h0);

      // T6: 4-bit maximal sequence returns to its start every 15 steps
      load = 1; lv20 = 20'h00001; lv4 = 4'h1; tick(); load = 0; step_en = 1;
      for (int r = 0; r < 2; r++) begin
         repeat (15) tick();
         check("t6_return", 64'(lf_s), 64'h1);
`ifdef LFSR_PERIOD_MON_EN
         check("t6_wrap", 64'(wrap_o[2]), 64'h1);
         check("t6_period", period_o[2], 64'd15);
`endif
      end
      step_en = 0;

      // Randomised traffic against the model
      for (int n = 0; n < 400; n++) begin
         load        = ($urandom_range(0, 15) == 0);
         lv20        = ($urandom_range(0, 3) == 0) ? 20'h0 : 20'($urandom);
         lv4         = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
         step_en     = 1'($urandom);
         burst_start = ($urandom_range(0, 7) == 0);
         burst_len   = 16'($urandom_range(0, 6));
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
